// File: rtl/score_pkg.sv
// rtl/score_pkg.sv - shared types, constants and BCD helper for score_tracker
package score_pkg;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        PLAY    = 2'd1,
        COMPARE = 2'd2,
        SHOW    = 2'd3
    } state_e;

    localparam int SCORE_W_DEF = 8;
    localparam int BCD_W       = 12;
    localparam int SCORE_MAX   = (1 << SCORE_W_DEF) - 1;

    // One double-dabble correction step: add 3 to every digit that is >= 5.
    function automatic logic [BCD_W-1:0] dabble_adj(input logic [BCD_W-1:0] v);
        logic [BCD_W-1:0] r;
        r = v;
        for (int i = 0; i < BCD_W / 4; i++) begin
            if (r[4*i +: 4] >= 4'd5) begin
                r[4*i +: 4] = r[4*i +: 4] + 4'd3;
            end
        end
        return r;
    endfunction

endpackage

// File: rtl/score_tracker_if.sv
// rtl/score_tracker_if.sv - round control and score readout bundle; BCD signals exist only with SCORE_BCD_EN
interface score_tracker_if
    import score_pkg::*;
#(
    parameter int SCORE_W = SCORE_W_DEF
);
    logic               start;
    logic               point;
    logic               game_over;
    logic [SCORE_W-1:0] current_score;
    logic [SCORE_W-1:0] high_score;
    logic               playing;
    logic               result_valid;
    logic               new_record;
`ifdef SCORE_BCD_EN
    logic [BCD_W-1:0]   score_bcd;
    logic [BCD_W-1:0]   high_bcd;
    logic               bcd_valid;

    modport master (
        output start, point, game_over,
        input  current_score, high_score, playing, result_valid, new_record,
        input  score_bcd, high_bcd, bcd_valid
    );
    modport slave (
        input  start, point, game_over,
        output current_score, high_score, playing, result_valid, new_record,
        output score_bcd, high_bcd, bcd_valid
    );
`else
    modport master (
        output start, point, game_over,
        input  current_score, high_score, playing, result_valid, new_record
    );
    modport slave (
        input  start, point, game_over,
        output current_score, high_score, playing, result_valid, new_record
    );
`endif
endinterface

// File: rtl/bin2bcd.sv
// rtl/bin2bcd.sv - sequential double-dabble converter, restarts whenever its input changes
module bin2bcd
    import score_pkg::*;
#(
    parameter int W = SCORE_W_DEF
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [W-1:0]     bin,
    output logic [BCD_W-1:0] bcd,
    output logic             done
);
    localparam int CNT_W = $clog2(W + 1);

    logic [W-1:0]     last_q;
    logic [W-1:0]     sr_q;
    logic [BCD_W-1:0] acc_q;
    logic [BCD_W-1:0] bcd_q;
    logic [CNT_W-1:0] cnt_q;
    logic             busy_q;
    logic             done_q;
    logic [BCD_W-1:0] acc_next;

    assign acc_next = (dabble_adj(acc_q) << 1) | BCD_W'(sr_q[W-1]);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            last_q <= '0;
            sr_q   <= '0;
            acc_q  <= '0;
            bcd_q  <= '0;
            cnt_q  <= CNT_W'(W);
            busy_q <= 1'b1;
            done_q <= 1'b0;
        end else if (bin != last_q) begin
            last_q <= bin;
            sr_q   <= bin;
            acc_q  <= '0;
            cnt_q  <= CNT_W'(W);
            busy_q <= 1'b1;
            done_q <= 1'b0;
        end else if (busy_q) begin
            sr_q  <= sr_q << 1;
            acc_q <= acc_next;
            cnt_q <= cnt_q - 1'b1;
            if (cnt_q == CNT_W'(1)) begin
                bcd_q  <= acc_next;
                busy_q <= 1'b0;
                done_q <= 1'b1;
            end
        end
    end

    // A fresh source value invalidates the result before the restart is registered.
    assign done = done_q && (bin == last_q);
    assign bcd  = bcd_q;

endmodule

// File: rtl/score_tracker.sv
// rtl/score_tracker.sv - round score counter and high-score keeper; SCORE_BCD_EN adds BCD readouts
module score_tracker
    import score_pkg::*;
#(
    parameter int SCORE_W     = SCORE_W_DEF,
    parameter int HOLD_CYCLES = 4
) (
    input  logic           clk,
    input  logic           rst,
    score_tracker_if.slave bus
);
    localparam int                 CNT_W   = $clog2(HOLD_CYCLES + 1);
    localparam logic [SCORE_W-1:0] SAT_MAX = {SCORE_W{1'b1}};

    state_e             state_q;
    logic [SCORE_W-1:0] cur_q;
    logic [SCORE_W-1:0] high_q;
    logic               playing_q;
    logic               valid_q;
    logic               rec_q;
    logic [CNT_W-1:0]   hold_q;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q   <= IDLE;
            cur_q     <= '0;
            high_q    <= '0;
            playing_q <= 1'b0;
            valid_q   <= 1'b0;
            rec_q     <= 1'b0;
            hold_q    <= '0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (bus.start) begin
                        cur_q     <= '0;
                        playing_q <= 1'b1;
                        state_q   <= PLAY;
                    end
                end
                PLAY: begin
                    if (bus.point && cur_q != SAT_MAX) begin
                        cur_q <= cur_q + 1'b1;
                    end
                    if (bus.game_over) begin
                        playing_q <= 1'b0;
                        state_q   <= COMPARE;
                    end
                end
                COMPARE: begin
                    if (cur_q > high_q) begin
                        high_q <= cur_q;
                        rec_q  <= 1'b1;
                    end else begin
                        rec_q  <= 1'b0;
                    end
                    valid_q <= 1'b1;
                    hold_q  <= CNT_W'(HOLD_CYCLES - 1);
                    state_q <= SHOW;
                end
                SHOW: begin
                    if (hold_q == '0) begin
                        valid_q <= 1'b0;
                        rec_q   <= 1'b0;
                        state_q <= IDLE;
                    end else begin
                        hold_q <= hold_q - 1'b1;
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    assign bus.current_score = cur_q;
    assign bus.high_score    = high_q;
    assign bus.playing       = playing_q;
    assign bus.result_valid  = valid_q;
    assign bus.new_record    = rec_q;

`ifdef SCORE_BCD_EN
    logic score_done;
    logic high_done;

    bin2bcd #(.W(SCORE_W)) u_score_bcd (
        .clk  (clk),
        .rst  (rst),
        .bin  (cur_q),
        .bcd  (bus.score_bcd),
        .done (score_done)
    );

    bin2bcd #(.W(SCORE_W)) u_high_bcd (
        .clk  (clk),
        .rst  (rst),
        .bin  (high_q),
        .bcd  (bus.high_bcd),
        .done (high_done)
    );

    assign bus.bcd_valid = score_done && high_done;
`endif

endmodule

// File: tb/tb_score_tracker.sv
// tb/tb_score_tracker.sv - scoreboard bench for score_tracker; BCD checks build with SCORE_BCD_EN
module tb_score_tracker;
    import score_pkg::*;

    localparam int SW   = 8;
    localparam int HOLD = 4;

    typedef struct packed {
        logic [SW-1:0] cur;
        logic [SW-1:0] high;
        logic          rec;
    } res_t;

    logic clk = 1'b0;
    logic rst = 1'b1;

    score_tracker_if #(.SCORE_W(SW)) bus ();

    score_tracker #(.SCORE_W(SW), .HOLD_CYCLES(HOLD)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;

    res_t sb_q[$];
    int   checks = 0;
    int   errors = 0;
    int   m_score = 0;
    int   m_high  = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got %0d expected %0d", tag, got, exp);
        end
    endtask

    // Result monitor: pops the expected round result when result_valid rises.
    logic prev_v = 1'b0;
    int   vlen   = 0;
    always @(negedge clk) begin
        if (bus.result_valid && !prev_v) begin
            if (sb_q.size() == 0) begin
                check("sb_unexpected", 32'd1, 32'd0);
            end else begin
                res_t e;
                e = sb_q.pop_front();
                check("res_cur",  32'(bus.current_score), 32'(e.cur));
                check("res_high", 32'(bus.high_score),    32'(e.high));
                check("res_rec",  32'(bus.new_record),    32'(e.rec));
            end
        end
        if (bus.result_valid) begin
            vlen++;
        end else if (prev_v) begin
            check("hold_len", 32'(vlen), 32'(HOLD));
            vlen = 0;
        end
        prev_v = bus.result_valid;
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic model_point();
        if (m_score < (1 << SW) - 1) m_score++;
    endtask

    task automatic begin_round(input int npts);
        bus.start = 1'b1;
        tick();
        bus.start = 1'b0;
        m_score = 0;
        check("start_clr", 32'(bus.current_score), 32'd0);
        check("playing_up", 32'(bus.playing), 32'd1);
        for (int i = 0; i < npts; i++) begin
            bus.point = 1'b1;
            tick();
            bus.point = 1'b0;
            model_point();
        end
    endtask

    task automatic end_round(input bit combined, input bit start_in_show);
        res_t r;
        bus.game_over = 1'b1;
        if (combined) bus.point = 1'b1;
        tick();
        bus.game_over = 1'b0;
        bus.point     = 1'b0;
        if (combined) model_point();
        r.cur  = SW'(m_score);
        r.rec  = (m_score > m_high);
        if (m_score > m_high) m_high = m_score;
        r.high = SW'(m_high);
        sb_q.push_back(r);
        check("playing_down", 32'(bus.playing), 32'd0);
        check("valid_early", 32'(bus.result_valid), 32'd0);
        tick();
        check("valid_rise", 32'(bus.result_valid), 32'd1);
        if (start_in_show) begin
            bus.start = 1'b1;
            tick();
            bus.start = 1'b0;
        end
        for (int i = 0; i < 20 && bus.result_valid; i++) tick();
        check("show_exit", 32'(bus.result_valid), 32'd0);
        check("idle_playing", 32'(bus.playing), 32'd0);
        check("idle_rec", 32'(bus.new_record), 32'd0);
        check("score_hold", 32'(bus.current_score), 32'(m_score));
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog got timeout expected finish");
        $fatal(1);
    end

    initial begin
        bus.start     = 1'b0;
        bus.point     = 1'b0;
        bus.game_over = 1'b0;
        #2;
        check("rst_cur",     32'(bus.current_score), 32'd0);
        check("rst_high",    32'(bus.high_score),    32'd0);
        check("rst_playing", 32'(bus.playing),       32'd0);
        check("rst_valid",   32'(bus.result_valid),  32'd0);
        tick();
        tick();
        rst = 1'b0;
        tick();

        // Points pulsed while idle must be ignored.
        bus.point = 1'b1;
        tick();
        bus.point = 1'b0;
        check("idle_point", 32'(bus.current_score), 32'd0);

        begin_round(5);   end_round(1'b0, 1'b0);
        begin_round(3);   end_round(1'b0, 1'b0);
        begin_round(5);   end_round(1'b0, 1'b0);
        begin_round(300);
        check("saturate", 32'(bus.current_score), 32'd255);
        end_round(1'b0, 1'b0);
        begin_round(2);   end_round(1'b1, 1'b1);

        // Reset in the middle of a round: no comparison, everything clears at once.
        begin_round(7);
        rst = 1'b1;
        #1;
        check("mid_rst_cur",   32'(bus.current_score), 32'd0);
        check("mid_rst_high",  32'(bus.high_score),    32'd0);
        check("mid_rst_play",  32'(bus.playing),       32'd0);
        check("mid_rst_valid", 32'(bus.result_valid),  32'd0);
        check("mid_rst_rec",   32'(bus.new_record),    32'd0);
        m_high = 0;
        m_score = 0;
        tick();
        rst = 1'b0;
        tick();
        begin_round(1);   end_round(1'b0, 1'b0);
        check("post_rst_high", 32'(bus.high_score), 32'd1);

`ifdef SCORE_BCD_EN
        begin
            int n;
            begin_round(237);
            n = 0;
            while (!bus.bcd_valid && n < 20) begin
                tick();
                n++;
            end
            check("bcd_latency_ok", 32'(n <= 9), 32'd1);
            check("score_bcd", 32'(bus.score_bcd), 32'h237);
            end_round(1'b0, 1'b0);
            n = 0;
            while (!bus.bcd_valid && n < 20) begin
                tick();
                n++;
            end
            check("bcd_valid_high", 32'(bus.bcd_valid), 32'd1);
            check("high_bcd", 32'(bus.high_bcd), 32'h237);
        end
`endif

        tick();
        check("sb_drained", 32'(sb_q.size()), 32'd0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
